// File: rtl/bridge_arbiter_pkg.sv
// bridge_arbiter_pkg: shared FSM encoding, command/ID constants and defaults for bridge_arbiter
package bridge_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic RW_R = 1'b0;
  localparam logic RW_W = 1'b1;
  localparam logic M0_ID = 1'b0;
  localparam logic M1_ID = 1'b1;
  localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way grant, fixed M0 priority or round-robin on a last-grant pointer
// Ports: PClk/Reset clock and async reset; req0/req1 requests; update commits the grant; gnt winning master ID.
module rr_arbiter2 import bridge_arbiter_pkg::*; #(
  parameter int FIXED_PRI = 0
) (
  input  logic PClk,
  input  logic Reset,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic gnt
);
  logic last;
  // Reset to "M1 granted last" so the first contested grant goes to M0.
  always_ff @(posedge PClk or posedge Reset)
    if (Reset) last <= M1_ID;
    else if (update && (req0 || req1)) last <= gnt;
  assign gnt = (req0 && req1) ? ((FIXED_PRI != 0) ? M0_ID : ~last) : (req1 ? M1_ID : M0_ID);
endmodule

// File: rtl/bridge_arbiter.sv
// bridge_arbiter: arbitrates two masters onto one bridge port, one transaction at a time, with timeout
// Ports: PClk/Reset clock and async reset; M0_*/M1_* master request and response; Pr* registered
// bridge command, PrRData/PrReady bridge response; Busy high outside IDLE.
module bridge_arbiter import bridge_arbiter_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int FIXED_PRI = 0
) (
  input  logic        PClk,
  input  logic        Reset,
  input  logic        M0_Req,
  input  logic        M0_RW,
  input  logic [29:0] M0_A,
  input  logic [3:0]  M0_BE,
  input  logic [31:0] M0_WData,
  output logic        M0_Ready,
  output logic [31:0] M0_RData,
  output logic        M0_Err,
  input  logic        M1_Req,
  input  logic        M1_RW,
  input  logic [29:0] M1_A,
  input  logic [3:0]  M1_BE,
  input  logic [31:0] M1_WData,
  output logic        M1_Ready,
  output logic [31:0] M1_RData,
  output logic        M1_Err,
  output logic        PrReq,
  output logic        PrRW,
  output logic [29:0] PrA,
  output logic [3:0]  PrBE,
  output logic [31:0] PrWData,
  input  logic [31:0] PrRData,
  input  logic        PrReady,
  output logic        Busy
);
  state_t state, nxt;
  logic gnt, id, err, any_req, timeout;
  logic [7:0] cnt;
  logic [31:0] rdata;
  assign any_req = M0_Req || M1_Req;
  assign timeout = cnt == 8'(TIMEOUT - 1);
  rr_arbiter2 #(.FIXED_PRI(FIXED_PRI)) u_arb (
    .PClk(PClk), .Reset(Reset), .req0(M0_Req), .req1(M1_Req), .update(state == IDLE), .gnt(gnt)
  );
  always_ff @(posedge PClk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = any_req ? ISSUE : IDLE;
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = (PrReady || timeout) ? RESP : WAIT;
      default: nxt = IDLE;
    endcase
    PrReq = state == ISSUE;
    Busy = state != IDLE;
    M0_Ready = state == RESP && id == M0_ID;
    M1_Ready = state == RESP && id == M1_ID;
    M0_RData = M0_Ready ? rdata : '0;
    M1_RData = M1_Ready ? rdata : '0;
    M0_Err = M0_Ready && err;
    M1_Err = M1_Ready && err;
  end
  always_ff @(posedge PClk or posedge Reset)
    if (Reset) begin
      id <= M0_ID;
      PrRW <= RW_R;
      PrA <= '0;
      PrBE <= '0;
      PrWData <= '0;
      cnt <= '0;
      rdata <= '0;
      err <= 1'b0;
    end else if (state == IDLE && any_req) begin
      id <= gnt;
      PrRW <= gnt ? M1_RW : M0_RW;
      PrA <= gnt ? M1_A : M0_A;
      PrBE <= gnt ? M1_BE : M0_BE;
      PrWData <= gnt ? M1_WData : M0_WData;
    end else if (state == ISSUE) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      if (PrReady) begin
        rdata <= (PrRW == RW_R) ? PrRData : '0;
        err <= 1'b0;
      end else if (timeout) begin
        rdata <= '0;
        err <= 1'b1;
      end else if (cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
    end
endmodule

// File: tb/tb_bridge_arbiter.sv
// tb_bridge_arbiter: directed self-checking bench for bridge_arbiter, round-robin and fixed-priority instances
module tb_bridge_arbiter;
  import bridge_arbiter_pkg::*;
  logic PClk = 0, Reset = 1;
  logic M0_Req = 0, M1_Req = 0, M0_RW = 0, M1_RW = 0, PrReady = 0;
  logic [29:0] M0_A = 0, M1_A = 0;
  logic [3:0] M0_BE = 0, M1_BE = 0;
  logic [31:0] M0_WData = 0, M1_WData = 0, PrRData = 0;
  logic r_m0_ready, r_m1_ready, r_m0_err, r_m1_err, r_prreq, r_prrw, r_busy;
  logic f_m0_ready, f_m1_ready, f_m0_err, f_m1_err, f_prreq, f_prrw, f_busy;
  logic [31:0] r_m0_rdata, r_m1_rdata, r_prwdata, f_m0_rdata, f_m1_rdata, f_prwdata;
  logic [29:0] r_pra, f_pra;
  logic [3:0] r_prbe, f_prbe;
  int checks = 0, failures = 0;
  logic [31:0] ew;
  always #5 PClk = ~PClk;
  bridge_arbiter #(.TIMEOUT(15), .FIXED_PRI(0)) dut (
    .PClk(PClk), .Reset(Reset),
    .M0_Req(M0_Req), .M0_RW(M0_RW), .M0_A(M0_A), .M0_BE(M0_BE), .M0_WData(M0_WData),
    .M0_Ready(r_m0_ready), .M0_RData(r_m0_rdata), .M0_Err(r_m0_err),
    .M1_Req(M1_Req), .M1_RW(M1_RW), .M1_A(M1_A), .M1_BE(M1_BE), .M1_WData(M1_WData),
    .M1_Ready(r_m1_ready), .M1_RData(r_m1_rdata), .M1_Err(r_m1_err),
    .PrReq(r_prreq), .PrRW(r_prrw), .PrA(r_pra), .PrBE(r_prbe), .PrWData(r_prwdata),
    .PrRData(PrRData), .PrReady(PrReady), .Busy(r_busy)
  );
  bridge_arbiter #(.TIMEOUT(15), .FIXED_PRI(1)) dut_fp (
    .PClk(PClk), .Reset(Reset),
    .M0_Req(M0_Req), .M0_RW(M0_RW), .M0_A(M0_A), .M0_BE(M0_BE), .M0_WData(M0_WData),
    .M0_Ready(f_m0_ready), .M0_RData(f_m0_rdata), .M0_Err(f_m0_err),
    .M1_Req(M1_Req), .M1_RW(M1_RW), .M1_A(M1_A), .M1_BE(M1_BE), .M1_WData(M1_WData),
    .M1_Ready(f_m1_ready), .M1_RData(f_m1_rdata), .M1_Err(f_m1_err),
    .PrReq(f_prreq), .PrRW(f_prrw), .PrA(f_pra), .PrBE(f_prbe), .PrWData(f_prwdata),
    .PrRData(PrRData), .PrReady(PrReady), .Busy(f_busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge PClk);
    #1;
  endtask
  initial begin
    repeat (2) tick;
    check("rst_busy", 32'(r_busy), 0);
    check("rst_prreq", 32'(r_prreq), 0);
    check("rst_pra", 32'(r_pra), 0);
    check("rst_prwdata", r_prwdata, 0);
    check("rst_m0_ready", 32'(r_m0_ready), 0);
    check("rst_m0_rdata", r_m0_rdata, 0);
    check("rst_fp_busy", 32'(f_busy), 0);
    Reset = 0;
    M0_Req = 1; M0_RW = RW_R; M0_A = 30'h0900_0000; M0_BE = 4'hF;
    check("rd_c0_busy", 32'(r_busy), 0);
    tick;
    check("rd_c1_prreq", 32'(r_prreq), 1);
    check("rd_c1_pra", 32'(r_pra), 32'h0900_0000);
    check("rd_c1_prrw", 32'(r_prrw), 0);
    check("rd_c1_busy", 32'(r_busy), 1);
    tick;
    check("rd_c2_prreq", 32'(r_prreq), 0);
    PrReady = 1; PrRData = 32'h1234_5678;
    tick;
    PrReady = 0;
    check("rd_c3_m0_ready", 32'(r_m0_ready), 1);
    check("rd_c3_m0_rdata", r_m0_rdata, 32'h1234_5678);
    check("rd_c3_m0_err", 32'(r_m0_err), 0);
    check("rd_c3_m1_ready", 32'(r_m1_ready), 0);
    M0_Req = 0;
    tick;
    check("rd_c4_m0_ready", 32'(r_m0_ready), 0);
    check("rd_c4_busy", 32'(r_busy), 0);
    Reset = 1;
    tick;
    Reset = 0;
    M0_RW = RW_W; M1_RW = RW_W; M0_A = 30'h10; M1_A = 30'h20; M1_BE = 4'hF;
    M0_WData = 32'hA0A0_0001; M1_WData = 32'hB1B1_0002;
    M0_Req = 1; M1_Req = 1;
    for (int i = 0; i < 4; i++) begin
      ew = (i % 2 == 1) ? M1_WData : M0_WData;
      tick;
      check("rr_prreq", 32'(r_prreq), 1);
      check("rr_prwdata", r_prwdata, ew);
      check("fp_prwdata", f_prwdata, M0_WData);
      tick;
      PrReady = 1; PrRData = 32'h5555_5555;
      tick;
      PrReady = 0;
      check("rr_m0_ready", 32'(r_m0_ready), 1 - i % 2);
      check("rr_m1_ready", 32'(r_m1_ready), i % 2);
      check("rr_wr_rdata", r_m0_rdata | r_m1_rdata, 0);
      check("fp_m0_ready", 32'(f_m0_ready), 1);
      check("fp_m1_ready", 32'(f_m1_ready), 0);
      tick;
    end
    M0_Req = 0; M1_Req = 0;
    tick;
    M0_Req = 1; M0_RW = RW_W; M0_BE = 4'b0011; M0_WData = 32'hAABB_CCDD;
    tick;
    check("be_prreq", 32'(r_prreq), 1);
    check("be_prbe", 32'(r_prbe), 32'h3);
    check("be_prwdata", r_prwdata, 32'hAABB_CCDD);
    M0_BE = 4'hF; M0_WData = 32'h0;
    tick;
    check("be_prreq_once", 32'(r_prreq), 0);
    check("be_hold_prwdata", r_prwdata, 32'hAABB_CCDD);
    check("be_hold_prbe", 32'(r_prbe), 32'h3);
    PrReady = 1; PrRData = 32'hDEAD_BEEF;
    tick;
    PrReady = 0;
    check("be_m0_ready", 32'(r_m0_ready), 1);
    check("be_wr_rdata_zero", r_m0_rdata, 0);
    M0_Req = 0;
    tick;
    M1_Req = 1; M1_RW = RW_W; M1_WData = 32'h1111_2222;
    tick;
    check("to_prreq", 32'(r_prreq), 1);
    PrReady = 1;
    tick;
    PrReady = 0;
    repeat (14) tick;
    check("to_early_ready", 32'(r_m1_ready), 0);
    check("to_busy", 32'(r_busy), 1);
    tick;
    check("to_m1_ready", 32'(r_m1_ready), 1);
    check("to_m1_err", 32'(r_m1_err), 1);
    check("to_m1_rdata", r_m1_rdata, 0);
    check("to_m0_ready", 32'(r_m0_ready), 0);
    M1_Req = 0;
    tick;
    check("to_idle_busy", 32'(r_busy), 0);
    M0_Req = 1; M0_RW = RW_R; M0_A = 30'h55;
    tick;
    tick;
    check("ab_wait_busy", 32'(r_busy), 1);
    Reset = 1;
    #1;
    check("ab_async_busy", 32'(r_busy), 0);
    check("ab_async_pra", 32'(r_pra), 0);
    tick;
    Reset = 0; M0_Req = 0;
    PrReady = 1; PrRData = 32'h9999_9999;
    tick;
    PrReady = 0;
    check("ab_m0_ready", 32'(r_m0_ready), 0);
    check("ab_m1_ready", 32'(r_m1_ready), 0);
    check("ab_busy", 32'(r_busy), 0);
    tick;
    check("ab_late_ready", 32'(r_m0_ready | r_m1_ready), 0);
    M0_Req = 1;
    tick;
    check("ab_new_prreq", 32'(r_prreq), 1);
    check("ab_new_pra", 32'(r_pra), 32'h55);
    tick;
    PrReady = 1; PrRData = 32'hCAFE_F00D;
    tick;
    PrReady = 0; M0_Req = 0;
    check("ab_new_m0_ready", 32'(r_m0_ready), 1);
    check("ab_new_m0_rdata", r_m0_rdata, 32'hCAFE_F00D);
    check("ab_new_m0_err", 32'(r_m0_err), 0);
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bridge_arbiter.md
BRIDGE_ARBITER -- requirements
Module: bridge_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles in WAIT before an error response; range 2..255.
REQ-002 Parameter FIXED_PRI, default 0: 1 = M0 always wins, 0 = round-robin.
REQ-003 PClk  in  1  sole clock; all state updates on posedge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 M0_Req / M1_Req  in  1  master request; held high, with command stable, until that master's Ready.
REQ-006 M0_RW / M1_RW  in  1  RW_R=read, RW_W=write.
REQ-007 M0_A / M1_A  in  30  word address [31:2].
REQ-008 M0_BE / M1_BE  in  4  byte enables.
REQ-009 M0_WData / M1_WData  in  32  write data.
REQ-010 M0_Ready / M1_Ready  out  1  one-cycle completion pulse.
REQ-011 M0_RData / M1_RData  out  32  read data, valid while that master's Ready is high.
REQ-012 M0_Err / M1_Err  out  1  timeout flag, valid while that master's Ready is high.
REQ-013 PrReq  out  1  one-cycle bridge request pulse.
REQ-014 PrRW, PrA[31:2], PrBE[3:0], PrWData[31:0]  out  registered command to the bridge.
REQ-015 PrRData  in  32  bridge read data.
REQ-016 PrReady  in  1  bridge completion pulse.
REQ-017 Busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP; encoding lives in the shared package.
REQ-019 IDLE, no Req: remain in IDLE; Pr* outputs hold their last values; PrReq=0.
REQ-020 IDLE, any Req: select the winner; latch its RW/A/BE/WData into the Pr* registers; record its ID; go to ISSUE.
REQ-021 Both Req, FIXED_PRI=0: winner = master not granted last; pointer updates only on a grant.
REQ-022 Both Req, FIXED_PRI=1: M0 wins.
REQ-023 ISSUE: PrReq=1 for exactly one cycle; clear the wait counter; go to WAIT.
REQ-024 WAIT, PrReady=1: latch PrRData (reads; zero for writes); Err=0; go to RESP.
REQ-025 WAIT, no PrReady, counter = TIMEOUT-1: RData=0; Err=1; go to RESP.
REQ-026 WAIT otherwise: increment the counter, which saturates and never wraps.
REQ-027 PrReady arriving in IDLE, ISSUE or RESP is ignored.
REQ-028 RESP: granted master's Ready=1 for one cycle with RData/Err; the other master's Ready=0; go to IDLE.
REQ-029 Latency with an immediate bridge: Req high in IDLE at cycle 0 -> PrReq cycle 1 -> PrReady cycle 2 -> Ready cycle 3.
REQ-030 Ungranted master's Req stays pending and is never dropped.
REQ-031 Requests are never pipelined: at most one bridge transaction in flight.
REQ-032 Changes to a master's inputs after the latch in IDLE have no effect on the current transaction.
REQ-033 A Req still high in the IDLE cycle after RESP is treated as a new request.

Reset
REQ-034 Reset asserted: state=IDLE immediately, independent of PClk.
REQ-035 Reset values: all Ready/Err/RData/Pr* outputs=0, Busy=0, counter=0, round-robin pointer favours M0.
REQ-036 Reset mid-transaction aborts it with no Ready pulse; any late PrReady is ignored per REQ-027.

Structure
REQ-037 Shared parameter package holds: FSM state encoding, RW_R/RW_W, master IDs, TIMEOUT default.
REQ-038 The two-way grant logic (priority mode plus last-grant pointer) is a separate sub-module rr_arbiter2.
REQ-039 The FSM, counter and datapath registers reside in bridge_arbiter.

Verification
REQ-040 M0 read, A=0x24000000>>2, BE=4'hF, PrRData=0x12345678 on PrReady in cycle 2 -> M0_Ready in cycle 3, M0_RData=0x12345678, M0_Err=0.
REQ-041 M0 and M1 requesting together, FIXED_PRI=0, both held -> grants alternate M0,M1,M0,M1; each Ready lines up with its own PrWData.
REQ-042 Same stimulus, FIXED_PRI=1, M0 re-requesting the cycle after each Ready -> M1 never granted while M0_Req stays high.
REQ-043 M1 write, PrReady never asserted, TIMEOUT=15 -> M1_Ready 15 cycles after entering WAIT, M1_Err=1, M1_RData=0.
REQ-044 Reset asserted during WAIT, then PrReady pulse -> no Ready on either master; Busy=0; next request served normally.
REQ-045 M0 write with BE=4'b0011, WData=0xAABBCCDD -> PrReq high exactly one cycle with PrBE=4'b0011 and PrWData=0xAABBCCDD.
